// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
//   Bus-slave front end for a word-organised on-chip SRAM.  A one-cycle
//   S_CLAIM in IDLE captures the transfer attributes. The responder then
//   steps through the burst: WAIT_STATES stall cycles, then one data beat,
//   repeated for every beat. Illegal transfers, and beats that fall outside
//   the storage window, get a two-cycle error response instead.
//
//   Optional feature macro: SRAM_RESPONDER_WRITE_EN
//     defined   : write transfers update storage (byte-lane granular).
//     undefined : storage is read-only, has no write port, and any write
//                 claim gets the error response.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words of storage
//   BASE_ADDR    byte address of word 0
//   WAIT_STATES  stall cycles before every beat (0..15)
//
// Ports
//   CLK           clock, all logic on the rising edge
//   RSTN          synchronous reset, active HIGH despite the name
//   S_ADDR        byte address of the first beat (sampled with S_CLAIM)
//   S_WRITE_DATA  write data of the current beat
//   S_READ_DATA   read data of the current beat, held between beats
//   S_WRITE       1 = write, 0 = read (sampled with S_CLAIM)
//   S_SIZE        0 byte, 1 halfword, 2 word
//   S_BURST       SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
//   S_READYOUT    1 when idle or when a beat completes this cycle
//   S_RESP        1 during the error response
//   S_CLAIM       one-cycle request strobe
// ---------------------------------------------------------------------------
module sram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] S_ADDR,
  input  logic [31:0] S_WRITE_DATA,
  output logic [31:0] S_READ_DATA,
  input  logic        S_WRITE,
  input  logic [2:0]  S_SIZE,
  input  logic [2:0]  S_BURST,
  output logic        S_READYOUT,
  output logic        S_RESP,
  input  logic        S_CLAIM
);

  localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN       = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS         = 4'(WAIT_STATES);
  localparam logic [2:0]  BURST_INCR = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_BEAT = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // True when a byte address lies inside the storage window.
  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return ({1'b0, off} < SPAN);
  endfunction

  // Word index of a byte address inside the storage window.
  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    return AW'((addr - BASE_ADDR) >> 2);
  endfunction

  // Number of beats of a burst encoding.
  function automatic logic [4:0] burst_len(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: burst_len = 5'd4;
      3'd4, 3'd5: burst_len = 5'd8;
      3'd6, 3'd7: burst_len = 5'd16;
      default:    burst_len = 5'd1;
    endcase
  endfunction

  // Address misaligned to the transfer size.
  function automatic logic misaligned(input logic [1:0] lsb, input logic [2:0] size);
    case (size)
      3'd1:    misaligned = lsb[0];
      3'd2:    misaligned = (lsb != 2'd0);
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Address of the following beat. WRAP bursts (even non-zero encodings)
  // stay inside a beats*size aligned block; INCR bursts roll over at 2^32.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [2:0] burst);
    logic [31:0] inc;
    logic [31:0] mask;
    inc  = 32'd1 << size;
    mask = ({27'd0, burst_len(burst)} << size) - 32'd1;
    if ((burst[0] == 1'b0) && (burst != 3'd0)) begin
      next_addr = (addr & ~mask) | ((addr + inc) & mask);
    end else begin
      next_addr = addr + inc;
    end
  endfunction

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;
  logic [2:0]  burst_q, burst_d;
  logic [4:0]  beats_q, beats_d;
  logic [3:0]  wait_q, wait_d;
  logic        readyout_q, readyout_d;
  logic        resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        claim_err_s;
  logic [31:0] nxt_addr_s;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Transfer-level legality check applied at claim time.
  always_comb begin
    claim_err_s = (S_BURST == BURST_INCR) || (S_SIZE > 3'd2) ||
                  misaligned(S_ADDR[1:0], S_SIZE) || !in_range(S_ADDR);
`ifndef SRAM_RESPONDER_WRITE_EN
    claim_err_s = claim_err_s || S_WRITE;
`endif
  end

  // Next-state and transfer bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beats_d    = beats_q;
    wait_d     = wait_q;
    nxt_addr_s = next_addr(addr_q, size_q, burst_q);
    case (state_q)
      ST_IDLE: begin
        if (S_CLAIM) begin
          addr_d  = S_ADDR;
          write_d = S_WRITE;
          size_d  = S_SIZE;
          burst_d = S_BURST;
          beats_d = burst_len(S_BURST);
          if (claim_err_s) begin
            state_d = ST_ERR1;
          end else if (WS != 4'd0) begin
            state_d = ST_WAIT;
            wait_d  = WS - 4'd1;
          end else begin
            state_d = ST_BEAT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = ST_BEAT;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_BEAT: begin
        beats_d = beats_q - 5'd1;
        if (beats_d != 5'd0) begin
          addr_d = nxt_addr_s;
          // Each later beat is range-checked before it is allowed to access.
          if (!in_range(nxt_addr_s)) begin
            state_d = ST_ERR1;
          end else if (WS != 4'd0) begin
            state_d = ST_WAIT;
            wait_d  = WS - 4'd1;
          end else begin
            state_d = ST_BEAT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
        beats_d = 5'd0;
      end
      ST_ERR2: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    readyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    resp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    // Fetch ahead so read data is valid throughout the beat cycle.
    if ((state_d == ST_BEAT) && !write_d) begin
      rdata_d = mem_q[word_idx(addr_d)];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'd0;
      write_q    <= 1'b0;
      size_q     <= 3'd0;
      burst_q    <= 3'd0;
      beats_q    <= 5'd0;
      wait_q     <= 4'd0;
      readyout_q <= 1'b1;
      resp_q     <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beats_q    <= beats_d;
      wait_q     <= wait_d;
      readyout_q <= readyout_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef SRAM_RESPONDER_WRITE_EN
  // Byte lanes touched by a beat, little-endian.
  function automatic logic [3:0] lane_mask(input logic [1:0] lsb, input logic [2:0] size);
    case (size)
      3'd0:    lane_mask = 4'b0001 << lsb;
      3'd1:    lane_mask = lsb[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  logic          mem_we_s;
  logic [3:0]    lane_s;
  logic [AW-1:0] widx_s;

  // Write strobe for the current beat; a reset in the beat cycle cancels it.
  always_comb begin
    mem_we_s = (state_q == ST_BEAT) && write_q && !RSTN;
    lane_s   = lane_mask(addr_q[1:0], size_q);
    widx_s   = word_idx(addr_q);
  end

  // Storage write port, lane-masked; contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_s[b]) begin
          mem_q[widx_s][8*b +: 8] <= S_WRITE_DATA[8*b +: 8];
        end
      end
    end
  end
`else
  logic unused_wdata_s;
  assign unused_wdata_s = ^S_WRITE_DATA;
`endif

  assign S_READYOUT  = readyout_q;
  assign S_RESP      = resp_q;
  assign S_READ_DATA = rdata_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder. Two instances share the request
// inputs and have separate claim strobes: u_dut0 has WAIT_STATES=0, u_dut1
// has WAIT_STATES=1. The expected cycle pattern and data of each transfer are
// queued when it is planned. They are popped and compared as the DUT responds.
module tb_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_write;
  logic [2:0]  s_size;
  logic [2:0]  s_burst;
  logic        claim0;
  logic        claim1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        rdy0;
  logic        rdy1;
  logic        resp0;
  logic        resp1;

  sram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
    .CLK(clk), .RSTN(rstn), .S_ADDR(s_addr), .S_WRITE_DATA(s_wdata), .S_READ_DATA(rdata0),
    .S_WRITE(s_write), .S_SIZE(s_size), .S_BURST(s_burst), .S_READYOUT(rdy0),
    .S_RESP(resp0), .S_CLAIM(claim0));

  sram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut1 (
    .CLK(clk), .RSTN(rstn), .S_ADDR(s_addr), .S_WRITE_DATA(s_wdata), .S_READ_DATA(rdata1),
    .S_WRITE(s_write), .S_SIZE(s_size), .S_BURST(s_burst), .S_READYOUT(rdy1),
    .S_RESP(resp1), .S_CLAIM(claim1));

  typedef struct packed {
    logic rdy;
    logic resp;
    logic beat;
    logic wr;
  } cyc_t;

  cyc_t        cyc_q[$];
  logic [31:0] data_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] wsrc[$];
  logic [31:0] mdl [2][1024];
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic cyc_t mk(input logic r, input logic p, input logic b, input logic w);
    cyc_t c;
    c.rdy  = r;
    c.resp = p;
    c.beat = b;
    c.wr   = w;
    return c;
  endfunction

  function automatic int m_len(input logic [2:0] bu);
    case (bu)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] a, input logic [2:0] sz, input logic [2:0] bu);
    logic [31:0] inc;
    logic [31:0] bnd;
    inc = 32'd1 << sz;
    bnd = 32'(m_len(bu)) << sz;
    if (bu == 3'd2 || bu == 3'd4 || bu == 3'd6) begin
      return (a & ~(bnd - 32'd1)) | ((a + inc) & (bnd - 32'd1));
    end
    return a + inc;
  endfunction

  function automatic logic rdy_of(input int sel);
    return (sel == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic resp_of(input int sel);
    return (sel == 0) ? resp0 : resp1;
  endfunction

  function automatic logic [31:0] rdata_of(input int sel);
    return (sel == 0) ? rdata0 : rdata1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue the expected response of one transfer, updating the model memory.
  task automatic plan(input int sel, input logic [31:0] a, input logic wr,
                      input logic [2:0] sz, input logic [2:0] bu);
    logic [31:0] addr;
    logic [31:0] d;
    logic [31:0] w;
    logic        bad;
    int          n;
    int          ws;
    ws  = (sel == 0) ? 0 : 1;
    bad = (bu == 3'd1) || (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'd0);
`ifndef SRAM_RESPONDER_WRITE_EN
    bad = bad || wr;
`endif
    n    = m_len(bu);
    addr = a;
    for (int k = 0; k < n && !bad; k++) begin
      if (addr >= 32'h1000) begin
        bad = 1'b1;
      end else begin
        repeat (ws) cyc_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
        cyc_q.push_back(mk(1'b1, 1'b0, 1'b1, wr));
        if (wr) begin
          d = wsrc.pop_front();
          wd_q.push_back(d);
          w = mdl[sel][addr[11:2]];
          for (int b = 0; b < 4; b++) begin
            if ((sz == 3'd0 && b == int'(addr[1:0])) || (sz == 3'd1 && (b / 2) == int'(addr[1])) ||
                sz == 3'd2) begin
              w[8*b +: 8] = d[8*b +: 8];
            end
          end
          mdl[sel][addr[11:2]] = w;
        end else begin
          data_q.push_back(mdl[sel][addr[11:2]]);
        end
        addr = m_next(addr, sz, bu);
      end
    end
    if (bad) begin
      cyc_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
      cyc_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
    end
  endtask

  task automatic issue(input int sel, input logic [31:0] a, input logic wr,
                       input logic [2:0] sz, input logic [2:0] bu);
    @(negedge clk);
    s_addr  = a;
    s_write = wr;
    s_size  = sz;
    s_burst = bu;
    if (sel == 0) claim0 = 1'b1;
    else claim1 = 1'b1;
    @(negedge clk);
    claim0 = 1'b0;
    claim1 = 1'b0;
  endtask

  // Compare every queued cycle, then require the idle response.
  task automatic drain(input int sel, input string tag, input logic stray);
    cyc_t c;
    int   idx;
    idx = 0;
    while (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      if (stray && idx == 0) begin
        s_addr  = 32'h0000_0ff0;
        s_burst = 3'd0;
        if (sel == 0) claim0 = 1'b1;
        else claim1 = 1'b1;
      end else begin
        claim0 = 1'b0;
        claim1 = 1'b0;
      end
      if (c.beat && c.wr) s_wdata = wd_q.pop_front();
      chk($sformatf("%s rdy[%0d]", tag, idx), {31'd0, rdy_of(sel)}, {31'd0, c.rdy});
      chk($sformatf("%s resp[%0d]", tag, idx), {31'd0, resp_of(sel)}, {31'd0, c.resp});
      if (c.beat && !c.wr) chk($sformatf("%s data[%0d]", tag, idx), rdata_of(sel), data_q.pop_front());
      idx++;
      @(negedge clk);
    end
    claim0 = 1'b0;
    claim1 = 1'b0;
    chk($sformatf("%s idle rdy", tag), {31'd0, rdy_of(sel)}, 32'd1);
    chk($sformatf("%s idle resp", tag), {31'd0, resp_of(sel)}, 32'd0);
  endtask

  task automatic run(input int sel, input string tag, input logic [31:0] a, input logic wr,
                     input logic [2:0] sz, input logic [2:0] bu);
    plan(sel, a, wr, sz, bu);
    issue(sel, a, wr, sz, bu);
    drain(sel, tag, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn    = 1'b1;
    claim0  = 1'b0;
    claim1  = 1'b0;
    s_addr  = 32'd0;
    s_wdata = 32'd0;
    s_write = 1'b0;
    s_size  = 3'd0;
    s_burst = 3'd0;
    for (int i = 0; i < 1024; i++) begin
      mdl[0][i] = 32'hC0DE_0000 + 32'(i * 3);
      mdl[1][i] = 32'hC0DE_0000 + 32'(i * 3);
    end
    for (int i = 0; i < 4; i++) begin
      mdl[0][i] = 32'(11 * (i + 1));
      mdl[1][i] = 32'(11 * (i + 1));
    end
`ifndef SRAM_RESPONDER_WRITE_EN
    for (int i = 0; i < 1024; i++) begin
      u_dut0.mem_q[i] = mdl[0][i];
      u_dut1.mem_q[i] = mdl[1][i];
    end
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset rdy0", {31'd0, rdy0}, 32'd1);
    chk("reset resp0", {31'd0, resp0}, 32'd0);
    chk("reset rdata0", rdata0, 32'd0);
    chk("reset rdy1", {31'd0, rdy1}, 32'd1);
    chk("reset resp1", {31'd0, resp1}, 32'd0);
    chk("reset rdata1", rdata1, 32'd0);
    rstn = 1'b0;

`ifdef SRAM_RESPONDER_WRITE_EN
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1024; i++) begin
        if (i < 16 || i >= 1020) begin
          wsrc.push_back(mdl[s][i]);
          run(s, "preload", 32'(i * 4), 1'b1, 3'd2, 3'd0);
        end
      end
    end
`endif

    // WRAP4 word read at 0x8 with one wait state: fixed pattern and data
    for (int k = 0; k < 4; k++) begin
      cyc_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
      cyc_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0));
    end
    data_q.push_back(32'd33);
    data_q.push_back(32'd44);
    data_q.push_back(32'd11);
    data_q.push_back(32'd22);
    issue(1, 32'h8, 1'b0, 3'd2, 3'd2);
    drain(1, "wrap4", 1'b0);

    run(1, "misalign_word", 32'h2, 1'b0, 3'd2, 3'd0);
    run(1, "incr8_edge_ws1", 32'hFF0, 1'b0, 3'd2, 3'd5);
    run(0, "incr8_edge_ws0", 32'hFF0, 1'b0, 3'd2, 3'd5);
    run(0, "incr_undef", 32'h0, 1'b0, 3'd2, 3'd1);
    run(1, "size3", 32'h0, 1'b0, 3'd3, 3'd0);
    run(0, "misalign_half", 32'h1, 1'b0, 3'd1, 3'd0);
    run(0, "out_of_range", 32'h1000, 1'b0, 3'd2, 3'd0);
    run(0, "byte_single", 32'h3, 1'b0, 3'd0, 3'd0);
    run(1, "half_wrap4", 32'h6, 1'b0, 3'd1, 3'd2);
    run(0, "byte_incr4", 32'h2, 1'b0, 3'd0, 3'd3);
    run(0, "word_wrap16", 32'h14, 1'b0, 3'd2, 3'd6);

    // A claim while busy must not disturb the running burst
    plan(1, 32'h0, 1'b0, 3'd2, 3'd3);
    issue(1, 32'h0, 1'b0, 3'd2, 3'd3);
    drain(1, "busy_claim", 1'b1);

`ifdef SRAM_RESPONDER_WRITE_EN
    wsrc.push_back(32'hAAAA_AAAA);
    wsrc.push_back(32'hBBBB_BBBB);
    wsrc.push_back(32'hCCCC_CCCC);
    wsrc.push_back(32'hDDDD_DDDD);
    run(0, "half_write", 32'h10, 1'b1, 3'd1, 3'd3);
    cyc_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0));
    data_q.push_back(32'hBBBB_AAAA);
    issue(0, 32'h10, 1'b0, 3'd2, 3'd0);
    drain(0, "half_write_rd10", 1'b0);
    cyc_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0));
    data_q.push_back(32'hDDDD_CCCC);
    issue(0, 32'h14, 1'b0, 3'd2, 3'd0);
    drain(0, "half_write_rd14", 1'b0);
`else
    wsrc.push_back(32'h5);
    run(1, "ro_write", 32'h0, 1'b1, 3'd2, 3'd0);
    cyc_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    cyc_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0));
    data_q.push_back(32'd11);
    issue(1, 32'h0, 1'b0, 3'd2, 3'd0);
    drain(1, "ro_readback", 1'b0);
`endif

    // Reset during beat 2 of a WRAP8, with a claim in the reset cycle
    issue(1, 32'h0, 1'b0, 3'd2, 3'd4);
    chk("rst_mid w1", {31'd0, rdy1}, 32'd0);
    @(negedge clk);
    chk("rst_mid b1 rdy", {31'd0, rdy1}, 32'd1);
    chk("rst_mid b1 data", rdata1, mdl[1][0]);
    @(negedge clk);
    chk("rst_mid w2", {31'd0, rdy1}, 32'd0);
    @(negedge clk);
    chk("rst_mid b2 data", rdata1, mdl[1][1]);
    rstn    = 1'b1;
    claim1  = 1'b1;
    s_addr  = 32'h8;
    s_size  = 3'd2;
    s_burst = 3'd0;
    s_write = 1'b0;
    @(negedge clk);
    rstn   = 1'b0;
    claim1 = 1'b0;
    chk("rst_mid after rdy", {31'd0, rdy1}, 32'd1);
    chk("rst_mid after resp", {31'd0, resp1}, 32'd0);
    chk("rst_mid after data", rdata1, 32'd0);
    @(negedge clk);
    chk("rst_claim ignored", {31'd0, rdy1}, 32'd1);
    run(1, "post_reset", 32'h4, 1'b0, 3'd2, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
